// File: rtl/imem_stream_loader.sv
// imem_stream_loader
//   Synthesizable writer for the byte-wide instruction memory. A byte stream
//   arriving on a valid/ready handshake is written from address 0 upward, one
//   byte per cycle, with a one-cycle registered write port. A trailing partial
//   word is padded with PAD_BYTE. The pipeline is held in reset for RESET_HOLD
//   cycles after the load ends and is then released (pipe_reset=0, pipe_LE=1).
//   Optional feature: define IMEM_LOAD_CHECKSUM_EN to build a mod-256 checksum
//   of the accepted stream bytes; otherwise checksum is tied to 8'h00.
module imem_stream_loader #(
    parameter int         DEPTH      = 512,
    parameter int         ADDR_W     = 9,
    parameter int         RESET_HOLD = 3,
    parameter logic [7:0] PAD_BYTE   = 8'h00
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    input  logic              load_last,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic [ADDR_W:0]   byte_count,
    output logic              overflow,
    output logic              busy,
    output logic              pipe_LE,
    output logic              pipe_reset,
    output logic [7:0]        checksum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PAD,
        S_HOLD,
        S_RUN
    } state_e;

    localparam int                HOLD_W    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
    localparam logic [ADDR_W-1:0] WPTR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W + 1)'(DEPTH);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                ovf_q, ovf_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          data_q, data_d;

    logic                xfer;
    logic                start_load;

    // A byte moves only while loading; a new load may begin only from IDLE or RUN.
    assign xfer       = (state_q == S_LOAD) && byte_valid;
    assign start_load = start && ((state_q == S_IDLE) || (state_q == S_RUN));

    // Next-state, write-port and counter logic for the load sequence.
    always_comb begin
        // NOTE: every _d gets its default first so no path through the case infers a latch.
        state_d = state_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        hold_d  = hold_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;

        case (state_q)
            S_IDLE, S_RUN: begin
                if (start_load) begin
                    state_d = S_LOAD;
                    wptr_d  = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end

            S_LOAD: begin
                if (xfer) begin
                    we_d   = 1'b1;
                    addr_d = wptr_q;
                    data_d = byte_in;
                    if (count_q != COUNT_MAX) begin
                        count_d = count_q + 1'b1;
                    end
                    // The pointer parks on the last byte rather than wrapping to 0.
                    if (wptr_q != WPTR_LAST) begin
                        wptr_d = wptr_q + 1'b1;
                    end
                    if (load_last) begin
                        hold_d  = '0;
                        state_d = (wptr_q[1:0] == 2'b11) ? S_HOLD : S_PAD;
                    end else if (wptr_q == WPTR_LAST) begin
                        hold_d  = '0;
                        ovf_d   = 1'b1;
                        state_d = S_HOLD;
                    end
                end
            end

            S_PAD: begin
                we_d   = 1'b1;
                addr_d = wptr_q;
                data_d = PAD_BYTE;
                if (wptr_q != WPTR_LAST) begin
                    wptr_d = wptr_q + 1'b1;
                end
                // This pad byte completes the word when it lands on offset 3.
                if (wptr_q[1:0] == 2'b11) begin
                    hold_d  = '0;
                    state_d = S_HOLD;
                end
            end

            S_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = S_RUN;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and write-port registers; clr also cancels a write already queued.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (clr) begin
            state_q <= S_IDLE;
            wptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            hold_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            hold_q  <= hold_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;

    // Running mod-256 sum of accepted stream bytes; pad bytes never reach it.
    always_comb begin
        sum_d = sum_q;
        if (start_load) begin
            sum_d = '0;
        end else if (xfer) begin
            sum_d = sum_q + byte_in;
        end
    end

    // Checksum register, cleared with the rest of the loader.
    always_ff @(posedge clk) begin
        if (clr) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 8'h00;
`endif

    assign byte_ready = (state_q == S_LOAD);
    assign busy       = (state_q == S_LOAD) || (state_q == S_PAD) || (state_q == S_HOLD);
    assign pipe_LE    = (state_q == S_RUN);
    assign pipe_reset = (state_q != S_RUN);
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_data   = data_q;
    assign byte_count = count_q;
    assign overflow   = ovf_q;

endmodule
